// File: rtl/ex_mem_stage_if.sv
// EX/MEM boundary bundle: EX results and ctrl stall/flush in, MEM-side registers
// plus the madd/msub carry-back and bubble counter out.
interface ex_mem_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2,
  parameter int PERF_W = 16
);
  logic                stall_ex;
  logic                stall_mem;
  logic                flush;
  logic                ex_valid;
  logic [ADDR_W-1:0]   ex_waddr;
  logic                ex_wreg;
  logic [DATA_W-1:0]   ex_wdata;
  logic [DATA_W-1:0]   ex_hi;
  logic [DATA_W-1:0]   ex_lo;
  logic                ex_whilo;
  logic [2*DATA_W-1:0] ex_hilo_temp;
  logic [CNT_W-1:0]    ex_cnt;

  logic                mem_valid;
  logic [ADDR_W-1:0]   mem_waddr;
  logic                mem_wreg;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_hi;
  logic [DATA_W-1:0]   mem_lo;
  logic                mem_whilo;
  logic [2*DATA_W-1:0] hilo_temp_o;
  logic [CNT_W-1:0]    cnt_o;
  logic [PERF_W-1:0]   bubble_cnt;

  modport master (
    output stall_ex, stall_mem, flush, ex_valid, ex_waddr, ex_wreg, ex_wdata,
           ex_hi, ex_lo, ex_whilo, ex_hilo_temp, ex_cnt,
    input  mem_valid, mem_waddr, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo,
           hilo_temp_o, cnt_o, bubble_cnt
  );

  modport slave (
    input  stall_ex, stall_mem, flush, ex_valid, ex_waddr, ex_wreg, ex_wdata,
           ex_hi, ex_lo, ex_whilo, ex_hilo_temp, ex_cnt,
    output mem_valid, mem_waddr, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo,
           hilo_temp_o, cnt_o, bubble_cnt
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with flush/bubble/hold control, valid bit,
// madd/msub intermediate carry-back and a saturating bubble counter.
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2,
  parameter int PERF_W = 16
) (
  input logic           clk,
  input logic           rst,
  ex_mem_stage_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_ADVANCE,
    MODE_HOLD,
    MODE_BUBBLE,
    MODE_FLUSH
  } mode_t;

  mode_t mode;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + PERF_W'(1);
  endfunction

  always_comb begin
    mode = MODE_ADVANCE;
    if (bus.flush)                          mode = MODE_FLUSH;
    else if (bus.stall_ex && bus.stall_mem) mode = MODE_HOLD;
    else if (bus.stall_ex)                  mode = MODE_BUBBLE;
  end

  // EX -> MEM register boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_valid   <= 1'b0;
      bus.mem_waddr   <= '0;
      bus.mem_wreg    <= 1'b0;
      bus.mem_wdata   <= '0;
      bus.mem_hi      <= '0;
      bus.mem_lo      <= '0;
      bus.mem_whilo   <= 1'b0;
      bus.hilo_temp_o <= '0;
      bus.cnt_o       <= '0;
      bus.bubble_cnt  <= '0;
    end else begin
      case (mode)
        MODE_FLUSH: begin
          bus.mem_valid   <= 1'b0;
          bus.mem_waddr   <= '0;
          bus.mem_wreg    <= 1'b0;
          bus.mem_wdata   <= '0;
          bus.mem_hi      <= '0;
          bus.mem_lo      <= '0;
          bus.mem_whilo   <= 1'b0;
          bus.hilo_temp_o <= '0;
          bus.cnt_o       <= '0;
        end
        MODE_BUBBLE: begin
          // NOP goes to MEM while EX keeps its partial madd/msub result alive
          bus.mem_valid   <= 1'b0;
          bus.mem_waddr   <= '0;
          bus.mem_wreg    <= 1'b0;
          bus.mem_wdata   <= '0;
          bus.mem_hi      <= '0;
          bus.mem_lo      <= '0;
          bus.mem_whilo   <= 1'b0;
          bus.hilo_temp_o <= bus.ex_hilo_temp;
          bus.cnt_o       <= bus.ex_cnt;
          bus.bubble_cnt  <= sat_inc(bus.bubble_cnt);
        end
        MODE_HOLD: begin
        end
        MODE_ADVANCE: begin
          bus.mem_valid   <= bus.ex_valid;
          bus.mem_waddr   <= bus.ex_waddr;
          bus.mem_wreg    <= bus.ex_wreg;
          bus.mem_wdata   <= bus.ex_wdata;
          bus.mem_hi      <= bus.ex_hi;
          bus.mem_lo      <= bus.ex_lo;
          bus.mem_whilo   <= bus.ex_whilo;
          bus.hilo_temp_o <= '0;
          bus.cnt_o       <= '0;
        end
      endcase
    end
  end

  // MEM stalled while EX runs is an encoding ctrl never produces; we still advance
  illegal_stall_encoding: assert property (@(posedge clk) disable iff (rst)
    !(!bus.flush && !bus.stall_ex && bus.stall_mem))
    else $error("ex_mem_stage: stall_mem asserted without stall_ex");

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: vector table for the single-cycle modes,
// plus hand sequences for asynchronous reset and bubble counter saturation.
module tb_ex_mem_stage;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ex_mem_stage_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(2), .PERF_W(4)) bus ();

  ex_mem_stage #(.DATA_W(32), .ADDR_W(5), .CNT_W(2), .PERF_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        fl, sx, sm, v;
    logic [4:0]  wa;
    logic        wr;
    logic [31:0] wd, hi, lo;
    logic        wh;
    logic [63:0] tmp;
    logic [1:0]  cnt;
    logic        e_v;
    logic [4:0]  e_wa;
    logic        e_wr;
    logic [31:0] e_wd, e_hi, e_lo;
    logic        e_wh;
    logic [63:0] e_tmp;
    logic [1:0]  e_cnt;
    logic [3:0]  e_bub;
  } vec_t;

  vec_t vec [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t x);
    bus.flush        = x.fl;
    bus.stall_ex     = x.sx;
    bus.stall_mem    = x.sm;
    bus.ex_valid     = x.v;
    bus.ex_waddr     = x.wa;
    bus.ex_wreg      = x.wr;
    bus.ex_wdata     = x.wd;
    bus.ex_hi        = x.hi;
    bus.ex_lo        = x.lo;
    bus.ex_whilo     = x.wh;
    bus.ex_hilo_temp = x.tmp;
    bus.ex_cnt       = x.cnt;
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [4:0] ewa,
                         input logic ewr, input logic [31:0] ewd, input logic [31:0] ehi,
                         input logic [31:0] elo, input logic ewh, input logic [63:0] etmp,
                         input logic [1:0] ecnt, input logic [3:0] ebub);
    chk({tag, ".mem_valid"},   bus.mem_valid,   ev);
    chk({tag, ".mem_waddr"},   bus.mem_waddr,   ewa);
    chk({tag, ".mem_wreg"},    bus.mem_wreg,    ewr);
    chk({tag, ".mem_wdata"},   bus.mem_wdata,   ewd);
    chk({tag, ".mem_hi"},      bus.mem_hi,      ehi);
    chk({tag, ".mem_lo"},      bus.mem_lo,      elo);
    chk({tag, ".mem_whilo"},   bus.mem_whilo,   ewh);
    chk({tag, ".hilo_temp_o"}, bus.hilo_temp_o, etmp);
    chk({tag, ".cnt_o"},       bus.cnt_o,       ecnt);
    chk({tag, ".bubble_cnt"},  bus.bubble_cnt,  ebub);
  endtask

  initial begin
    // advance
    vec[0]  = '{0,0,0,1, 5'd7, 1,32'hDEADBEEF,32'h11,32'h22,0, 64'h9,2'd3,
                1,5'd7, 1,32'hDEADBEEF,32'h11,32'h22,0, 64'h0,2'd0, 4'd0};
    // bubble carrying the madd intermediate back to EX
    vec[1]  = '{0,1,0,1, 5'd4, 1,32'hAAAAAAAA,32'h33,32'h44,1, 64'h0000_0001_0000_0002,2'd1,
                0,5'd0, 0,32'h0,32'h0,32'h0,0, 64'h0000_0001_0000_0002,2'd1, 4'd1};
    // resume: carry-back cleared
    vec[2]  = '{0,0,0,1, 5'd3, 0,32'hA5A5A5A5,32'h1,32'h2,1, 64'hFFFF,2'd2,
                1,5'd3, 0,32'hA5A5A5A5,32'h1,32'h2,1, 64'h0,2'd0, 4'd1};
    // invalid instruction: enables pass through unqualified
    vec[3]  = '{0,0,0,0, 5'd9, 1,32'h12345678,32'h5,32'h6,1, 64'h0,2'd0,
                0,5'd9, 1,32'h12345678,32'h5,32'h6,1, 64'h0,2'd0, 4'd1};
    // hold for three cycles with changing EX inputs
    vec[4]  = '{0,1,1,1, 5'd31,1,32'hFFFFFFFF,32'h7,32'h8,0, 64'h55,2'd3,
                0,5'd9, 1,32'h12345678,32'h5,32'h6,1, 64'h0,2'd0, 4'd1};
    vec[5]  = '{0,1,1,1, 5'd2, 0,32'h0BADF00D,32'h9,32'h9,1, 64'h66,2'd1,
                0,5'd9, 1,32'h12345678,32'h5,32'h6,1, 64'h0,2'd0, 4'd1};
    vec[6]  = '{0,1,1,0, 5'd1, 1,32'h11111111,32'hA,32'hB,0, 64'h67,2'd2,
                0,5'd9, 1,32'h12345678,32'h5,32'h6,1, 64'h0,2'd0, 4'd1};
    // bubble then hold keeps the carry-back
    vec[7]  = '{0,1,0,1, 5'd6, 1,32'h22222222,32'h3,32'h3,1, 64'hCAFE_0000_0000_BEEF,2'd2,
                0,5'd0, 0,32'h0,32'h0,32'h0,0, 64'hCAFE_0000_0000_BEEF,2'd2, 4'd2};
    vec[8]  = '{0,1,1,1, 5'd8, 1,32'h33333333,32'h1,32'h1,1, 64'h77,2'd3,
                0,5'd0, 0,32'h0,32'h0,32'h0,0, 64'hCAFE_0000_0000_BEEF,2'd2, 4'd2};
    // flush overrides bubble and hold
    vec[9]  = '{1,1,0,1, 5'd5, 1,32'h44444444,32'h1,32'h1,1, 64'h88,2'd1,
                0,5'd0, 0,32'h0,32'h0,32'h0,0, 64'h0,2'd0, 4'd2};
    vec[10] = '{1,1,1,1, 5'd5, 1,32'h55555555,32'h2,32'h2,1, 64'h89,2'd1,
                0,5'd0, 0,32'h0,32'h0,32'h0,0, 64'h0,2'd0, 4'd2};
    vec[11] = '{0,0,0,1, 5'd31,1,32'hFFFFFFFF,32'h80000000,32'h7FFFFFFF,1, 64'h99,2'd1,
                1,5'd31,1,32'hFFFFFFFF,32'h80000000,32'h7FFFFFFF,1, 64'h0,2'd0, 4'd2};

    rst = 1'b1;
    apply('{default: '0});
    @(negedge clk);
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      apply(vec[i]);
      @(posedge clk);
      @(negedge clk);
      chk_all($sformatf("v%0d", i), vec[i].e_v, vec[i].e_wa, vec[i].e_wr, vec[i].e_wd,
              vec[i].e_hi, vec[i].e_lo, vec[i].e_wh, vec[i].e_tmp, vec[i].e_cnt, vec[i].e_bub);
    end

    // bubble loads a carry-back, then asynchronous reset mid-cycle wipes everything
    apply('{fl:0, sx:1, sm:0, v:1, wa:5'd3, wr:1, wd:32'h1, hi:32'h1, lo:32'h1, wh:1,
            tmp:64'h1234_5678_9ABC_DEF0, cnt:2'd1, default:'0});
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst.hilo_temp_o", bus.hilo_temp_o, 64'h1234_5678_9ABC_DEF0);
    chk("pre_rst.bubble_cnt",  bus.bubble_cnt,  4'd3);
    apply('{fl:0, sx:0, sm:0, v:1, wa:5'd12, wr:1, wd:32'hCAFEF00D, hi:32'h1, lo:32'h2, wh:1,
            tmp:64'h0, cnt:2'd0, default:'0});
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // saturation of a 4-bit counter over 20 back-to-back bubbles
    apply('{fl:0, sx:1, sm:0, v:1, wa:5'd1, wr:1, wd:32'h1, hi:32'h0, lo:32'h0, wh:0,
            tmp:64'h5, cnt:2'd1, default:'0});
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("sat%0d.bubble_cnt", k), bus.bubble_cnt, (k > 15) ? 4'hF : 4'(k));
    end
    apply('{fl:1, sx:1, sm:0, v:1, wa:5'd1, wr:1, wd:32'h1, hi:32'h0, lo:32'h0, wh:0,
            tmp:64'h5, cnt:2'd1, default:'0});
    @(posedge clk);
    @(negedge clk);
    chk("sat_flush.bubble_cnt", bus.bubble_cnt, 4'hF);
    chk("sat_flush.cnt_o",      bus.cnt_o,      2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
